mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single external memory port between instruction fetch (imem) and the
//   execute stage's load/store unit (dmem). Buffers one request per requester, grants
//   the bus to one at a time, holds the grant until mem_ready, and routes the response back.
//   Sits between fetch/execute stages and the memory/bus interface.
// PARAMETERS
//   XLEN    32  data width of rdata/wdata
//   ADDR_W  32  address width
// PORTS
//   clk         in   1        clock; all state updates on posedge
//   rst         in   1        reset, synchronous, active-low
//   imem_valid  in   1        fetch request strobe (single-cycle pulse)
//   imem_addr   in   ADDR_W   fetch address
//   imem_flush  in   1        drop pending/outstanding fetch (branch redirect)
//   imem_ready  out  1        fetch response valid (single cycle)
//   imem_rdata  out  XLEN     fetch response data
//   dmem_valid  in   1        load/store request strobe (single-cycle pulse)
//   dmem_addr   in   ADDR_W   data address
//   dmem_wdata  in   XLEN     store data
//   dmem_wstrb  in   XLEN/8   byte strobes; all-zero = load
//   dmem_ready  out  1        data response valid (single cycle)
//   dmem_rdata  out  XLEN     load data
//   mem_valid   out  1        bus request strobe (registered, single cycle)
//   mem_instr   out  1        1 = current bus transaction is a fetch
//   mem_addr    out  ADDR_W   bus address (held until mem_ready)
//   mem_wdata   out  XLEN     bus store data (held)
//   mem_wstrb   out  XLEN/8   bus byte strobes (held)
//   mem_ready   in   1        bus response valid
//   mem_rdata   in   XLEN     bus response data
// BEHAVIOUR
//   - Reset (rst==0 at posedge): state=IDLE, both buffers empty, mem_valid/mem_instr=0,
//     mem_addr/wdata/wstrb=0, imem_ready=dmem_ready=0; an in-flight mem_ready after reset ignored.
//   - Capture: *_valid loads that requester's 1-entry buffer. Buffer full and not freed
//     this cycle -> new strobe ignored (protocol violation; sim assertion). Strobe in same
//     cycle its response returns -> accepted.
//   - FSM states IDLE, IBUSY, DBUSY. IDLE + pending -> busy state of winner; mem_valid=1 for
//     exactly the first cycle of busy; addr/wdata/wstrb/mem_instr held for whole busy period.
//   - Busy + mem_ready: response forwarded combinationally same cycle (owner *_ready=1,
//     *_rdata=mem_rdata; non-owner ready=0, rdata=0); owner buffer freed; if other buffer
//     pending go directly to its busy state (mem_valid next cycle), else IDLE.
//   - mem_ready in IDLE ignored. Best latency: strobe cycle N, mem_valid N+1, ready >= N+2.
//   - Priority (macro off): dmem beats imem when both pending at grant decision.
//   - imem_flush: empties imem buffer (same-cycle imem_valid is dropped too); if IBUSY,
//     marks transaction squashed -> imem_ready suppressed on completion, bus still completes.
//   - dmem is never flushed (execute stalls on it).
// CONFIGURATION
//   MEM_ARBITER_RR_EN defined: round-robin; when both pending, grant goes to the requester
//     NOT granted last (last_grant reg, reset = imem so dmem wins first tie).
//   Undefined: fixed dmem priority; last_grant absent.
// STRUCTURE
//   Package wires: mem_in_type/mem_out_type structs, arb_state_type enum (IDLE/IBUSY/DBUSY),
//     arb_reg_type + init_arb_reg constant.
//   Sub-module arb_req_buffer (1-entry valid/addr/wdata/wstrb holding register with
//     load/free/flush), instantiated once per requester.
// TESTING
//   1 Reset: rst=0 2 cycles while mem_ready=1 -> all outputs 0, state IDLE.
//   2 Single load: dmem_valid@N addr=0x100 wstrb=0 -> mem_valid@N+1 mem_instr=0; mem_ready@N+3
//     rdata=0xDEADBEEF -> dmem_ready=1, dmem_rdata=0xDEADBEEF @N+3, imem_ready=0.
//   3 Collision: imem_valid & dmem_valid same cycle -> dmem served first, imem mem_valid in cycle
//     after dmem's mem_ready; with RR_EN second tie goes to imem.
//   4 Flush in flight: fetch 0x200 IBUSY, imem_flush before mem_ready -> mem_ready completes,
//     imem_ready stays 0, FSM IDLE.
//   5 Store with back-to-back: store wstrb=0xF wdata=0x12345678 while fetch pending -> bus sees
//     store then fetch, mem_wdata held stable until mem_ready.
//   6 Duplicate strobe: second dmem_valid while DBUSY -> ignored, assertion fires, one response only.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the memory arbiter slice.
//   XLEN / ADDR_W : data and address widths used by every file of the slice
//   mem_in_type   : bus response (ready, rdata)
//   mem_out_type  : bus request (valid, instr, addr, wdata, wstrb)
//   req_type      : one buffered requester entry
//   arb_reg_type  : arbiter register bank, init_arb_reg is its reset value
// Optional feature macro: MEM_ARBITER_RR_EN adds the last_grant field.
package mem_arbiter_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STRB_W = XLEN / 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIbusy = 2'd1,
        StDbusy = 2'd2
    } arb_state_type;

    typedef enum logic {
        GrantImem = 1'b0,
        GrantDmem = 1'b1
    } grant_type;

    typedef struct packed {
        logic            ready;
        logic [XLEN-1:0] rdata;
    } mem_in_type;

    typedef struct packed {
        logic              valid;
        logic              instr;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_out_type;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
    } req_type;

    typedef struct packed {
        arb_state_type state;
        mem_out_type   mem_out;
        logic          squash;
`ifdef MEM_ARBITER_RR_EN
        grant_type     last_grant;
`endif
    } arb_reg_type;

    // StIdle and GrantImem both encode as zero, so all-zero is the reset value.
    localparam arb_reg_type init_arb_reg = arb_reg_type'('0);

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one memory request/response channel.
//   master drives : valid, instr, flush, addr, wdata, wstrb
//   slave drives  : ready, rdata
// Used for the fetch port, the load/store port and the external bus port.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              valid;
    logic              instr;
    logic              flush;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] wstrb;
    logic              ready;
    logic [XLEN-1:0]   rdata;

    modport master (
        output valid, instr, flush, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, instr, flush, addr, wdata, wstrb,
        output ready, rdata
    );

endinterface

// File: rtl/mem_arbiter_arb_req_buffer.sv
// arb_req_buffer: 1-entry request holding register.
//   clk, rst            : clock, synchronous active-low reset
//   load_i              : capture addr/wdata/wstrb (ignored when full and not freed)
//   free_i              : release the held entry (served)
//   flush_i             : empty the entry; a same-cycle load is dropped
//   addr_i/wdata_i/wstrb_i : request payload
//   valid_o/addr_o/wdata_o/wstrb_o : held entry
//   drop_o              : a load arrived while full and was ignored
module arb_req_buffer
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              free_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [STRB_W-1:0] wstrb_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic              drop_o
);

    req_type buf_q, buf_d;

    always_comb begin
        buf_d  = buf_q;
        drop_o = 1'b0;
        if (flush_i) begin
            buf_d.valid = 1'b0;
        end else if (load_i && (!buf_q.valid || free_i)) begin
            buf_d.valid = 1'b1;
            buf_d.addr  = addr_i;
            buf_d.wdata = wdata_i;
            buf_d.wstrb = wstrb_i;
        end else begin
            drop_o = load_i;
            if (free_i) begin
                buf_d.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign valid_o = buf_q.valid;
    assign addr_o  = buf_q.addr;
    assign wdata_o = buf_q.wdata;
    assign wstrb_o = buf_q.wstrb;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port between fetch and load/store.
//   clk, rst : clock, synchronous active-low reset
//   imem     : fetch channel (slave); valid/addr/flush in, ready/rdata out
//   dmem     : load/store channel (slave); valid/addr/wdata/wstrb in, ready/rdata out
//   mem      : external bus (master); valid/instr/addr/wdata/wstrb out, ready/rdata in
// Widths come from mem_arbiter_pkg (XLEN, ADDR_W).
// Macros: MEM_ARBITER_RR_EN selects round-robin arbitration (default: dmem priority).
//         MEM_ARBITER_PROTO_ASSERT enables the duplicate-strobe simulation check.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  imem,
    mem_arbiter_if.slave  dmem,
    mem_arbiter_if.master mem
);

    arb_reg_type r_q, r_d;
    mem_in_type  bus_in;
    mem_out_type ireq, dreq;

    logic              ibuf_valid, dbuf_valid;
    logic [ADDR_W-1:0] ibuf_addr, dbuf_addr;
    logic [XLEN-1:0]   ibuf_wdata, dbuf_wdata;
    logic [STRB_W-1:0] ibuf_wstrb, dbuf_wstrb;
    logic              imem_drop, dmem_drop;
    logic              imem_load, imem_free, dmem_free;
    logic              imem_ack, dmem_ack;
    logic              done, pend_i, pend_d, prefer_i;
    logic              grant_i, grant_d;

    assign bus_in = '{ready: mem.ready, rdata: mem.rdata};

    // A response only counts while a transaction is outstanding.
    assign done      = bus_in.ready && (r_q.state != StIdle);
    assign imem_load = imem.valid && !imem.flush;
    // A squashed fetch must not free the buffer: it may already hold the redirected fetch.
    assign imem_free = done && (r_q.state == StIbusy) && !r_q.squash;
    assign dmem_free = done && (r_q.state == StDbusy);

    arb_req_buffer u_ibuf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (imem_load),
        .free_i  (imem_free),
        .flush_i (imem.flush),
        .addr_i  (imem.addr),
        .wdata_i ('0),
        .wstrb_i ('0),
        .valid_o (ibuf_valid),
        .addr_o  (ibuf_addr),
        .wdata_o (ibuf_wdata),
        .wstrb_o (ibuf_wstrb),
        .drop_o  (imem_drop)
    );

    arb_req_buffer u_dbuf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (dmem.valid),
        .free_i  (dmem_free),
        .flush_i (1'b0),
        .addr_i  (dmem.addr),
        .wdata_i (dmem.wdata),
        .wstrb_i (dmem.wstrb),
        .valid_o (dbuf_valid),
        .addr_o  (dbuf_addr),
        .wdata_o (dbuf_wdata),
        .wstrb_o (dbuf_wstrb),
        .drop_o  (dmem_drop)
    );

    // Pending includes this cycle's strobe so a grant can issue the cycle after it.
    assign pend_i = !imem.flush && (ibuf_valid || imem.valid);
    assign pend_d = dbuf_valid || dmem.valid;

    always_comb begin
        ireq       = '0;
        ireq.valid = 1'b1;
        ireq.instr = 1'b1;
        ireq.addr  = ibuf_valid ? ibuf_addr : imem.addr;

        dreq       = '0;
        dreq.valid = 1'b1;
        dreq.addr  = dbuf_valid ? dbuf_addr  : dmem.addr;
        dreq.wdata = dbuf_valid ? dbuf_wdata : dmem.wdata;
        dreq.wstrb = dbuf_valid ? dbuf_wstrb : dmem.wstrb;
    end

`ifdef MEM_ARBITER_RR_EN
    assign prefer_i = (r_q.last_grant == GrantDmem);
`else
    assign prefer_i = 1'b0;
`endif

    always_comb begin
        r_d               = r_q;
        r_d.mem_out.valid = 1'b0;
        grant_i           = 1'b0;
        grant_d           = 1'b0;
        unique case (r_q.state)
            StIdle: begin
                grant_d = pend_d && !(pend_i && prefer_i);
                grant_i = pend_i && !grant_d;
            end
            StIbusy: begin
                if (imem.flush) begin
                    r_d.squash = 1'b1;
                end
                grant_d = done && pend_d;
            end
            StDbusy: begin
                grant_i = done && pend_i;
            end
            default: begin
                r_d.state = StIdle;
            end
        endcase

        if (done && !grant_i && !grant_d) begin
            r_d.state = StIdle;
        end
        if (grant_i) begin
            r_d.state   = StIbusy;
            r_d.mem_out = ireq;
            r_d.squash  = 1'b0;
`ifdef MEM_ARBITER_RR_EN
            r_d.last_grant = GrantImem;
`endif
        end
        if (grant_d) begin
            r_d.state   = StDbusy;
            r_d.mem_out = dreq;
            r_d.squash  = 1'b0;
`ifdef MEM_ARBITER_RR_EN
            r_d.last_grant = GrantDmem;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= init_arb_reg;
        end else begin
            r_q <= r_d;
        end
    end

    // A flush in the completion cycle also suppresses the fetch response.
    assign imem_ack = imem_free && !imem.flush;
    assign dmem_ack = dmem_free;

    assign imem.ready = imem_ack;
    assign imem.rdata = imem_ack ? bus_in.rdata : '0;
    assign dmem.ready = dmem_ack;
    assign dmem.rdata = dmem_ack ? bus_in.rdata : '0;

    assign mem.valid = r_q.mem_out.valid;
    assign mem.instr = r_q.mem_out.instr;
    assign mem.addr  = r_q.mem_out.addr;
    assign mem.wdata = r_q.mem_out.wdata;
    assign mem.wstrb = r_q.mem_out.wstrb;
    assign mem.flush = 1'b0;

`ifdef MEM_ARBITER_PROTO_ASSERT
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!imem_drop) else $error("imem strobe while request buffer full");
            assert (!dmem_drop) else $error("dmem strobe while request buffer full");
        end
    end
`endif

    // Channel fields that this block has no use for.
    logic unused_sig;
    assign unused_sig = ^{imem.instr, imem.wdata, imem.wstrb, dmem.instr, dmem.flush,
                          ibuf_wdata, ibuf_wstrb, imem_drop, dmem_drop};

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

`ifdef MEM_ARBITER_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mem_arbiter_if imem_if ();
    mem_arbiter_if dmem_if ();
    mem_arbiter_if mem_if ();

    mem_arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .imem (imem_if),
        .dmem (dmem_if),
        .mem  (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive point: just after the rising edge. Check point: falling edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    task automatic clear_strobes();
        imem_if.valid = 1'b0;
        imem_if.flush = 1'b0;
        dmem_if.valid = 1'b0;
    endtask

    task automatic collide(input bit dfirst, input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] rd1, input logic [31:0] rd2);
        next();
        imem_if.valid = 1'b1;
        imem_if.addr  = ia;
        dmem_if.valid = 1'b1;
        dmem_if.addr  = da;
        dmem_if.wstrb = 4'h0;
        dmem_if.wdata = 32'h0;
        probe();
        next();
        clear_strobes();
        probe();
        chk("col_first_valid", mem_if.valid, 1);
        chk("col_first_instr", mem_if.instr, !dfirst);
        chk("col_first_addr", mem_if.addr, dfirst ? da : ia);
        next();
        mem_if.ready = 1'b1;
        mem_if.rdata = rd1;
        probe();
        chk("col_first_dack", dmem_if.ready, dfirst);
        chk("col_first_iack", imem_if.ready, !dfirst);
        chk("col_first_rdata", dfirst ? dmem_if.rdata : imem_if.rdata, rd1);
        next();
        mem_if.ready = 1'b0;
        probe();
        chk("col_second_valid", mem_if.valid, 1);
        chk("col_second_instr", mem_if.instr, dfirst);
        chk("col_second_addr", mem_if.addr, dfirst ? ia : da);
        next();
        mem_if.ready = 1'b1;
        mem_if.rdata = rd2;
        probe();
        chk("col_second_dack", dmem_if.ready, !dfirst);
        chk("col_second_iack", imem_if.ready, dfirst);
        chk("col_second_rdata", dfirst ? imem_if.rdata : dmem_if.rdata, rd2);
        next();
        mem_if.ready = 1'b0;
        probe();
        chk("col_idle", dut.r_q.state, StIdle);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        imem_if.valid = 1'b0;
        imem_if.instr = 1'b0;
        imem_if.flush = 1'b0;
        imem_if.addr  = '0;
        imem_if.wdata = '0;
        imem_if.wstrb = '0;
        dmem_if.valid = 1'b0;
        dmem_if.instr = 1'b0;
        dmem_if.flush = 1'b0;
        dmem_if.addr  = '0;
        dmem_if.wdata = '0;
        dmem_if.wstrb = '0;
        mem_if.ready  = 1'b1;
        mem_if.rdata  = 32'hCAFE_F00D;

        // Reset held two cycles with a stray bus response present.
        next();
        next();
        probe();
        chk("rst_mem_valid", mem_if.valid, 0);
        chk("rst_mem_instr", mem_if.instr, 0);
        chk("rst_mem_addr", mem_if.addr, 0);
        chk("rst_mem_wdata", mem_if.wdata, 0);
        chk("rst_mem_wstrb", mem_if.wstrb, 0);
        chk("rst_imem_ready", imem_if.ready, 0);
        chk("rst_dmem_ready", dmem_if.ready, 0);
        chk("rst_state", dut.r_q.state, StIdle);
        rst = 1'b1;
        mem_if.ready = 1'b0;

        // Bus response while idle is ignored.
        next();
        mem_if.ready = 1'b1;
        probe();
        chk("idle_rdy_imem", imem_if.ready, 0);
        chk("idle_rdy_dmem", dmem_if.ready, 0);
        next();
        mem_if.ready = 1'b0;

        // First tie: dmem wins in both arbitration modes.
        collide(1'b1, 32'h300, 32'h104, 32'h11, 32'h22);

        // Single load.
        next();
        dmem_if.valid = 1'b1;
        dmem_if.addr  = 32'h100;
        dmem_if.wstrb = 4'h0;
        probe();
        chk("ld_valid_n", mem_if.valid, 0);
        next();
        clear_strobes();
        probe();
        chk("ld_valid_n1", mem_if.valid, 1);
        chk("ld_instr", mem_if.instr, 0);
        chk("ld_addr", mem_if.addr, 32'h100);
        next();
        probe();
        chk("ld_valid_n2", mem_if.valid, 0);
        chk("ld_addr_held", mem_if.addr, 32'h100);
        next();
        mem_if.ready = 1'b1;
        mem_if.rdata = 32'hDEAD_BEEF;
        probe();
        chk("ld_dack", dmem_if.ready, 1);
        chk("ld_drdata", dmem_if.rdata, 32'hDEAD_BEEF);
        chk("ld_iack", imem_if.ready, 0);
        chk("ld_irdata", imem_if.rdata, 0);
        next();
        mem_if.ready = 1'b0;
        probe();
        chk("ld_dack_off", dmem_if.ready, 0);
        chk("ld_idle", dut.r_q.state, StIdle);

        // Second tie right after a lone load: round-robin hands it to imem.
        collide(!RrEn, 32'h304, 32'h108, 32'h33, 32'h44);

        // Flush while the fetch is on the bus.
        next();
        imem_if.valid = 1'b1;
        imem_if.addr  = 32'h200;
        probe();
        next();
        clear_strobes();
        probe();
        chk("fl_valid", mem_if.valid, 1);
        chk("fl_instr", mem_if.instr, 1);
        chk("fl_addr", mem_if.addr, 32'h200);
        next();
        imem_if.flush = 1'b1;
        probe();
        chk("fl_ibusy", dut.r_q.state, StIbusy);
        next();
        imem_if.flush = 1'b0;
        mem_if.ready  = 1'b1;
        mem_if.rdata  = 32'h0000_AAAA;
        probe();
        chk("fl_iack", imem_if.ready, 0);
        chk("fl_irdata", imem_if.rdata, 0);
        chk("fl_dack", dmem_if.ready, 0);
        next();
        mem_if.ready = 1'b0;
        probe();
        chk("fl_idle", dut.r_q.state, StIdle);
        chk("fl_no_reissue", mem_if.valid, 0);

        // Store followed by a fetch that waits behind it.
        next();
        dmem_if.valid = 1'b1;
        dmem_if.addr  = 32'h10C;
        dmem_if.wdata = 32'h1234_5678;
        dmem_if.wstrb = 4'hF;
        probe();
        next();
        clear_strobes();
        imem_if.valid = 1'b1;
        imem_if.addr  = 32'h404;
        probe();
        chk("st_valid", mem_if.valid, 1);
        chk("st_instr", mem_if.instr, 0);
        chk("st_addr", mem_if.addr, 32'h10C);
        chk("st_wdata", mem_if.wdata, 32'h1234_5678);
        chk("st_wstrb", mem_if.wstrb, 4'hF);
        next();
        clear_strobes();
        dmem_if.wdata = 32'h0;
        dmem_if.wstrb = 4'h0;
        probe();
        chk("st_valid_drop", mem_if.valid, 0);
        chk("st_wdata_held", mem_if.wdata, 32'h1234_5678);
        chk("st_wstrb_held", mem_if.wstrb, 4'hF);
        next();
        probe();
        chk("st_wdata_held2", mem_if.wdata, 32'h1234_5678);
        next();
        mem_if.ready = 1'b1;
        mem_if.rdata = 32'h0;
        probe();
        chk("st_dack", dmem_if.ready, 1);
        chk("st_iack", imem_if.ready, 0);
        next();
        mem_if.ready = 1'b0;
        probe();
        chk("bb_valid", mem_if.valid, 1);
        chk("bb_instr", mem_if.instr, 1);
        chk("bb_addr", mem_if.addr, 32'h404);
        chk("bb_wstrb", mem_if.wstrb, 0);
        next();
        mem_if.ready = 1'b1;
        mem_if.rdata = 32'h55;
        probe();
        chk("bb_iack", imem_if.ready, 1);
        chk("bb_irdata", imem_if.rdata, 32'h55);
        chk("bb_dack", dmem_if.ready, 0);
        next();
        mem_if.ready = 1'b0;

        // Duplicate dmem strobe while the first is outstanding.
        next();
        dmem_if.valid = 1'b1;
        dmem_if.addr  = 32'h110;
        probe();
        next();
        clear_strobes();
        probe();
        chk("dup_first_valid", mem_if.valid, 1);
        chk("dup_first_addr", mem_if.addr, 32'h110);
        next();
        dmem_if.valid = 1'b1;
        dmem_if.addr  = 32'h114;
        probe();
        chk("dup_flagged", dut.dmem_drop, 1);
        next();
        clear_strobes();
        probe();
        chk("dup_flag_clear", dut.dmem_drop, 0);
        next();
        mem_if.ready = 1'b1;
        mem_if.rdata = 32'h77;
        probe();
        chk("dup_dack", dmem_if.ready, 1);
        chk("dup_drdata", dmem_if.rdata, 32'h77);
        next();
        mem_if.ready = 1'b0;
        probe();
        chk("dup_dack_off", dmem_if.ready, 0);
        chk("dup_idle", dut.r_q.state, StIdle);
        chk("dup_no_second", mem_if.valid, 0);
        next();
        probe();
        chk("dup_no_second2", mem_if.valid, 0);
        chk("dup_buf_empty", dut.dbuf_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
